// File: rtl/mirfak_defines_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mirfak_defines (package)
//  Description : Shared definitions for the Mirfak decode stage: control-word
//                layout, immediate / operand selector codes, exception
//                causes, the NOP encoding, the EX payload record and the
//                RV32I immediate decoder.
//  Revision    : 1.0 - parametrised valid/ready decode stage
// ============================================================================
package mirfak_defines;

   // Immediate format selector (codes 5..7 decode to an all-zero immediate)
   localparam logic [2:0] c_imm_i = 3'd0;
   localparam logic [2:0] c_imm_s = 3'd1;
   localparam logic [2:0] c_imm_b = 3'd2;
   localparam logic [2:0] c_imm_u = 3'd3;
   localparam logic [2:0] c_imm_j = 3'd4;

   // Operand A selector
   localparam logic [1:0] c_sel_a_rf   = 2'd0;
   localparam logic [1:0] c_sel_a_pc   = 2'd1;
   localparam logic [1:0] c_sel_a_pc4  = 2'd2;
   localparam logic [1:0] c_sel_a_zero = 2'd3;

   // Operand B selector
   localparam logic [1:0] c_sel_b_rf   = 2'd0;
   localparam logic [1:0] c_sel_b_imm  = 2'd1;
   localparam logic [1:0] c_sel_b_four = 2'd2;
   localparam logic [1:0] c_sel_b_zero = 2'd3;

   // Forwarding selector: 0 = register file, k = forwarding slice k-1
   localparam int c_fwd_rf = 0;

   // Exception causes
   localparam logic [3:0] E_INST_ADDR_MISALIGNED = 4'd0;
   localparam logic [3:0] E_ILLEGAL_INST         = 4'd2;

   // ADDI x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Decoder control word (first member is the MSB)
   typedef struct packed {
      logic       invalid;
      logic [2:0] br_funct;   // RV32I branch funct3
      logic       jalr;
      logic       jump;       // JAL
      logic       branch;
      logic [1:0] sel_b;
      logic [1:0] sel_a;
      logic [2:0] sel_imm;
   } ctrl_t;

   localparam int CTRL_SZ = $bits(ctrl_t);

   // Everything EX receives for one instruction
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic [31:0] mtval;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] lsu_wdata;
      logic        exception;
      logic [3:0]  xcause;
      logic        bubble;
      ctrl_t       control;
      logic [2:0]  cmp;       // {eq, lt, ltu}
   } ex_payload_t;

   // RV32I sign-extended immediates
   function automatic logic [31:0] imm_decode(input logic [31:0] instr,
                                              input logic [2:0]  sel);
      logic [31:0] imm;
      case (sel)
         c_imm_i: imm = {{20{instr[31]}}, instr[31:20]};
         c_imm_s: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         c_imm_b: imm = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
         c_imm_u: imm = {instr[31:12], 12'b0};
         c_imm_j: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mirfak_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : mirfak_register_file
//  Description : 32 x 32-bit register file, two asynchronous read ports and
//                one synchronous write port. x0 always reads zero. A read of
//                the address being written returns the old contents.
//  Ports       : clk_i                          clock
//                raddr_a_i/rdata_a_o            read port A
//                raddr_b_i/rdata_b_o            read port B
//                waddr_i/wdata_i/wen_i          write port
//  Revision    : 1.0 - initial release
// ============================================================================
module mirfak_register_file (
   input  logic        clk_i,
   input  logic [4:0]  raddr_a_i,
   input  logic [4:0]  raddr_b_i,
   output logic [31:0] rdata_a_o,
   output logic [31:0] rdata_b_o,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic        wen_i
);

   logic [31:0] r_regs [0:31];

   always_ff @(posedge clk_i) begin
      if (wen_i && (waddr_i != 5'd0)) begin
         r_regs[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : r_regs[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : r_regs[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/mirfak_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mirfak_decode_stage
//  Description : Instruction decode stage. Decodes immediates, reads the
//                register file, applies N-source operand forwarding,
//                resolves branches/jumps (or defers them to EX), raises
//                decode exceptions and hands the result to EX over a
//                valid/ready handshake with an optional one-entry skid.
//  Ports       : clk_i, rst_i                      clock, sync reset
//                id_valid_i/id_ready_o             IF handshake
//                id_pc_i .. id_control_i           IF payload
//                id_fwd_a_sel_i/id_fwd_b_sel_i     forwarding selects
//                fwd_data_i                        forwarding data
//                wb_waddr_i/wb_wdata_i/wb_wen_i    register-file write
//                flush_i                           kill IF + stage contents
//                ex_valid_o/ex_ready_i, ex_*       EX handshake and payload
//                pc_bj_target_o/take_branch_o      redirect to IF
//  Revision    : 1.0 - valid/ready handshake with skid buffer
// ============================================================================
module mirfak_decode_stage
   import mirfak_defines::*;
#(
   parameter  int NFWD         = 2,
   parameter  int EARLY_BRANCH = 1,
   parameter  int SKID         = 1,
   localparam int FSW          = $clog2(NFWD + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                id_valid_i,
   output logic                id_ready_o,
   input  logic [31:0]         id_pc_i,
   input  logic [31:0]         id_pc4_i,
   input  logic [31:0]         id_instruction_i,
   input  logic                id_if_exception_i,
   input  logic [3:0]          id_if_xcause_i,
   input  logic                id_bubble_i,
   input  logic [CTRL_SZ-1:0]  id_control_i,
   input  logic [FSW-1:0]      id_fwd_a_sel_i,
   input  logic [FSW-1:0]      id_fwd_b_sel_i,
   input  logic [32*NFWD-1:0]  fwd_data_i,
   input  logic [4:0]          wb_waddr_i,
   input  logic [31:0]         wb_wdata_i,
   input  logic                wb_wen_i,
   input  logic                flush_i,
   output logic                ex_valid_o,
   input  logic                ex_ready_i,
   output logic [31:0]         ex_pc_o,
   output logic [31:0]         ex_pc4_o,
   output logic [31:0]         ex_instruction_o,
   output logic [31:0]         ex_mtval_o,
   output logic [31:0]         ex_operand_a_o,
   output logic [31:0]         ex_operand_b_o,
   output logic [31:0]         ex_lsu_wdata_o,
   output logic                ex_exception_o,
   output logic [3:0]          ex_xcause_o,
   output logic                ex_bubble_o,
   output logic [CTRL_SZ-1:0]  ex_control_o,
   output logic [2:0]          ex_cmp_o,
   output logic [31:0]         pc_bj_target_o,
   output logic                take_branch_o
);

   typedef enum logic [0:0] {
      SKID_EMPTY = 1'b0,
      SKID_FULL  = 1'b1
   } skid_state_t;

   localparam ex_payload_t c_ex_reset = '{
      pc: 32'd0, pc4: 32'd0, instr: NOP, mtval: 32'd0,
      op_a: 32'd0, op_b: 32'd0, lsu_wdata: 32'd0,
      exception: 1'b0, xcause: 4'd0, bubble: 1'b0,
      control: '0, cmp: 3'd0
   };

   ctrl_t       w_ctrl;
   logic [31:0] w_rf_a, w_rf_b;
   logic [31:0] w_fdata_a, w_fdata_b;
   logic [31:0] w_imm, w_imm_i, w_imm_b, w_imm_j;
   logic        w_eq, w_lt, w_ltu, w_cond, w_taken, w_misaligned;
   logic [31:0] w_target;
   logic        w_accept, w_move;
   ex_payload_t w_new;

   ex_payload_t r_ex;
   ex_payload_t r_skid;
   logic        r_ex_valid;
   logic        r_id_ready;
   skid_state_t r_state;

   assign w_ctrl = ctrl_t'(id_control_i);

   mirfak_register_file u_rf (
      .clk_i     (clk_i),
      .raddr_a_i (id_instruction_i[19:15]),
      .raddr_b_i (id_instruction_i[24:20]),
      .rdata_a_o (w_rf_a),
      .rdata_b_o (w_rf_b),
      .waddr_i   (wb_waddr_i),
      .wdata_i   (wb_wdata_i),
      .wen_i     (wb_wen_i)
   );

   // Selects above NFWD fall through to zero
   function automatic logic [31:0] fwd_pick(input logic [FSW-1:0] sel,
                                            input logic [31:0]    rf);
      logic [31:0] v;
      v = '0;
      if (int'(sel) == c_fwd_rf) v = rf;
      for (int k = 1; k <= NFWD; k++) begin
         if (int'(sel) == k) v = fwd_data_i[32*(k-1) +: 32];
      end
      return v;
   endfunction

   assign w_fdata_a = fwd_pick(id_fwd_a_sel_i, w_rf_a);
   assign w_fdata_b = fwd_pick(id_fwd_b_sel_i, w_rf_b);

   assign w_imm   = imm_decode(id_instruction_i, w_ctrl.sel_imm);
   assign w_imm_i = imm_decode(id_instruction_i, c_imm_i);
   assign w_imm_b = imm_decode(id_instruction_i, c_imm_b);
   assign w_imm_j = imm_decode(id_instruction_i, c_imm_j);

   // Branch compare on the forwarded register values
   assign w_eq  = (w_fdata_a == w_fdata_b);
   assign w_lt  = ($signed(w_fdata_a) < $signed(w_fdata_b));
   assign w_ltu = (w_fdata_a < w_fdata_b);

   always_comb begin
      w_cond = 1'b0;
      case (w_ctrl.br_funct)
         3'b000:  w_cond = w_eq;
         3'b001:  w_cond = !w_eq;
         3'b100:  w_cond = w_lt;
         3'b101:  w_cond = !w_lt;
         3'b110:  w_cond = w_ltu;
         3'b111:  w_cond = !w_ltu;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_taken = w_ctrl.jalr || w_ctrl.jump || (w_ctrl.branch && w_cond);

   always_comb begin
      w_target = id_pc_i + w_imm_b;
      if (w_ctrl.jalr) begin
         w_target = (w_fdata_a + w_imm_i) & ~32'd1;
      end else if (w_ctrl.jump) begin
         w_target = id_pc_i + w_imm_j;
      end
   end

   assign w_misaligned   = w_taken && (w_target[1:0] != 2'b00);
   assign pc_bj_target_o = w_target;

   assign w_accept = id_valid_i && id_ready_o && !flush_i;
   assign w_move   = r_ex_valid && ex_ready_i;

   generate
      if (EARLY_BRANCH != 0) begin : g_early_branch
         assign take_branch_o = w_accept && w_taken;
      end else begin : g_late_branch
         assign take_branch_o = 1'b0;
      end
   endgenerate

   // Payload built from the values visible at accept time
   always_comb begin
      w_new           = c_ex_reset;
      w_new.pc        = id_pc_i;
      w_new.pc4       = id_pc4_i;
      w_new.instr     = id_instruction_i;
      w_new.bubble    = id_bubble_i;
      w_new.control   = w_ctrl;
      w_new.cmp       = {w_eq, w_lt, w_ltu};
      w_new.lsu_wdata = w_fdata_b;

      case (w_ctrl.sel_a)
         c_sel_a_rf:  w_new.op_a = w_fdata_a;
         c_sel_a_pc:  w_new.op_a = id_pc_i;
         c_sel_a_pc4: w_new.op_a = id_pc4_i;
         default:     w_new.op_a = 32'd0;
      endcase

      case (w_ctrl.sel_b)
         c_sel_b_rf:   w_new.op_b = w_fdata_b;
         c_sel_b_imm:  w_new.op_b = w_imm;
         c_sel_b_four: w_new.op_b = 32'd4;
         default:      w_new.op_b = 32'd0;
      endcase

      if (id_if_exception_i) begin
         w_new.exception = 1'b1;
         w_new.xcause    = id_if_xcause_i;
         w_new.mtval     = id_pc_i;
      end else if (w_misaligned) begin
         w_new.exception = 1'b1;
         w_new.xcause    = E_INST_ADDR_MISALIGNED;
         w_new.mtval     = w_target;
      end else if (w_ctrl.invalid) begin
         w_new.exception = 1'b1;
         w_new.xcause    = E_ILLEGAL_INST;
         w_new.mtval     = id_instruction_i;
      end
   end

   // EX register plus skid entry. FULL only arises when SKID != 0, since
   // without a skid an accept implies EX is free or draining.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ex       <= c_ex_reset;
         r_skid     <= c_ex_reset;
         r_ex_valid <= 1'b0;
         r_id_ready <= 1'b1;
         r_state    <= SKID_EMPTY;
      end else if (flush_i) begin
         r_ex_valid <= 1'b0;
         r_id_ready <= 1'b1;
         r_state    <= SKID_EMPTY;
      end else begin
         case (r_state)
            SKID_EMPTY: begin
               if (w_accept) begin
                  if (r_ex_valid && !ex_ready_i) begin
                     r_skid     <= w_new;
                     r_state    <= SKID_FULL;
                     r_id_ready <= 1'b0;
                  end else begin
                     r_ex       <= w_new;
                     r_ex_valid <= 1'b1;
                  end
               end else if (w_move) begin
                  r_ex_valid <= 1'b0;
               end
            end
            SKID_FULL: begin
               if (w_move) begin
                  r_ex       <= r_skid;
                  r_ex_valid <= 1'b1;
                  r_id_ready <= 1'b1;
                  r_state    <= SKID_EMPTY;
               end
            end
            default: begin
               r_state    <= SKID_EMPTY;
               r_id_ready <= 1'b1;
            end
         endcase
      end
   end

   generate
      if (SKID != 0) begin : g_ready_skid
         assign id_ready_o = r_id_ready;
      end else begin : g_ready_direct
         assign id_ready_o = ex_ready_i || !r_ex_valid;
      end
   endgenerate

   assign ex_valid_o       = r_ex_valid;
   assign ex_pc_o          = r_ex.pc;
   assign ex_pc4_o         = r_ex.pc4;
   assign ex_instruction_o = r_ex.instr;
   assign ex_mtval_o       = r_ex.mtval;
   assign ex_operand_a_o   = r_ex.op_a;
   assign ex_operand_b_o   = r_ex.op_b;
   assign ex_lsu_wdata_o   = r_ex.lsu_wdata;
   assign ex_exception_o   = r_ex.exception;
   assign ex_xcause_o      = r_ex.xcause;
   assign ex_bubble_o      = r_ex.bubble;
   assign ex_control_o     = r_ex.control;
   assign ex_cmp_o         = r_ex.cmp;

endmodule
`default_nettype wire

// File: tb/tb_mirfak_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mirfak_decode_stage
//  Description : Directed self-checking bench for mirfak_decode_stage. Two
//                instances (early and deferred branch resolution, NFWD=3)
//                share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mirfak_decode_stage;
   import mirfak_defines::*;

   localparam int NFWD = 3;
   localparam int FSW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic                id_valid;
   logic [31:0]         id_pc, id_pc4, id_instr;
   logic                if_exc;
   logic [3:0]          if_xcause;
   logic                bubble;
   logic [CTRL_SZ-1:0]  control;
   logic [FSW-1:0]      fwd_a_sel, fwd_b_sel;
   logic [32*NFWD-1:0]  fwd_data;
   logic [4:0]          wb_waddr;
   logic [31:0]         wb_wdata;
   logic                wb_wen;
   logic                flush;
   logic                ex_ready;

   logic                id_ready, ex_valid, ex_exc, ex_bub, take;
   logic [31:0]         ex_pc, ex_pc4, ex_instr, ex_mtval, ex_a, ex_b, ex_wd, target;
   logic [3:0]          ex_xc;
   logic [CTRL_SZ-1:0]  ex_ctrl;
   logic [2:0]          ex_cmp;

   logic                nb_id_ready, nb_ex_valid, nb_ex_exc, nb_ex_bub, nb_take;
   logic [31:0]         nb_pc, nb_pc4, nb_instr, nb_mtval, nb_a, nb_b, nb_wd, nb_target;
   logic [3:0]          nb_xc;
   logic [CTRL_SZ-1:0]  nb_ctrl;
   logic [2:0]          nb_cmp;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mirfak_decode_stage #(.NFWD(NFWD), .EARLY_BRANCH(1), .SKID(1)) dut (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(id_ready),
      .id_pc_i(id_pc), .id_pc4_i(id_pc4), .id_instruction_i(id_instr),
      .id_if_exception_i(if_exc), .id_if_xcause_i(if_xcause), .id_bubble_i(bubble),
      .id_control_i(control), .id_fwd_a_sel_i(fwd_a_sel), .id_fwd_b_sel_i(fwd_b_sel),
      .fwd_data_i(fwd_data), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
      .wb_wen_i(wb_wen), .flush_i(flush), .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
      .ex_pc_o(ex_pc), .ex_pc4_o(ex_pc4), .ex_instruction_o(ex_instr),
      .ex_mtval_o(ex_mtval), .ex_operand_a_o(ex_a), .ex_operand_b_o(ex_b),
      .ex_lsu_wdata_o(ex_wd), .ex_exception_o(ex_exc), .ex_xcause_o(ex_xc),
      .ex_bubble_o(ex_bub), .ex_control_o(ex_ctrl), .ex_cmp_o(ex_cmp),
      .pc_bj_target_o(target), .take_branch_o(take)
   );

   mirfak_decode_stage #(.NFWD(NFWD), .EARLY_BRANCH(0), .SKID(1)) dut_nb (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(nb_id_ready),
      .id_pc_i(id_pc), .id_pc4_i(id_pc4), .id_instruction_i(id_instr),
      .id_if_exception_i(if_exc), .id_if_xcause_i(if_xcause), .id_bubble_i(bubble),
      .id_control_i(control), .id_fwd_a_sel_i(fwd_a_sel), .id_fwd_b_sel_i(fwd_b_sel),
      .fwd_data_i(fwd_data), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
      .wb_wen_i(wb_wen), .flush_i(flush), .ex_valid_o(nb_ex_valid), .ex_ready_i(ex_ready),
      .ex_pc_o(nb_pc), .ex_pc4_o(nb_pc4), .ex_instruction_o(nb_instr),
      .ex_mtval_o(nb_mtval), .ex_operand_a_o(nb_a), .ex_operand_b_o(nb_b),
      .ex_lsu_wdata_o(nb_wd), .ex_exception_o(nb_ex_exc), .ex_xcause_o(nb_xc),
      .ex_bubble_o(nb_ex_bub), .ex_control_o(nb_ctrl), .ex_cmp_o(nb_cmp),
      .pc_bj_target_o(nb_target), .take_branch_o(nb_take)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CTRL_SZ-1:0] mk(input logic [2:0] sel_imm,
                                             input logic [1:0] sel_a,
                                             input logic [1:0] sel_b,
                                             input logic br, input logic jal,
                                             input logic jalr, input logic [2:0] f3,
                                             input logic inv);
      ctrl_t c;
      c = '0;
      c.sel_imm = sel_imm; c.sel_a = sel_a; c.sel_b = sel_b;
      c.branch = br; c.jump = jal; c.jalr = jalr; c.br_funct = f3; c.invalid = inv;
      return c;
   endfunction

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [CTRL_SZ-1:0] c);
      id_valid = 1'b1;
      id_pc    = pc;
      id_pc4   = pc + 32'd4;
      id_instr = ins;
      control  = c;
   endtask

   initial begin
      logic [CTRL_SZ-1:0] c_addi, c_jal;
      c_addi = mk(c_imm_i, c_sel_a_rf, c_sel_b_imm, 0, 0, 0, 3'b000, 0);
      c_jal  = mk(c_imm_j, c_sel_a_pc4, c_sel_b_zero, 0, 1, 0, 3'b000, 0);

      rst = 1; id_valid = 0; id_pc = 0; id_pc4 = 0; id_instr = NOP;
      if_exc = 0; if_xcause = 0; bubble = 0; control = '0;
      fwd_a_sel = 0; fwd_b_sel = 0; fwd_data = '0;
      wb_waddr = 0; wb_wdata = 0; wb_wen = 0; flush = 0; ex_ready = 1;

      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_instr", ex_instr, 32'h0000_0013);
      chk("rst_id_ready", id_ready, 1);
      chk("rst_op_a", ex_a, 0);
      chk("rst_cmp", nb_cmp, 0);
      tick();
      chk("rst_id_ready_n1", id_ready, 1);

      // Back-pressure: ADDI x1,x0,5 then ADDI x2,x0,7 with EX stalled
      ex_ready = 0;
      drive(32'h0, 32'h0050_0093, c_addi);
      tick();
      chk("bp1_valid", ex_valid, 1);
      chk("bp1_op_b", ex_b, 5);
      drive(32'h4, 32'h0070_0113, c_addi);
      tick();
      chk("bp2_ready", id_ready, 0);
      chk("bp2_op_b_hold", ex_b, 5);
      id_valid = 0;
      tick();
      chk("bp3_op_b_hold", ex_b, 5);
      chk("bp3_pc_hold", ex_pc, 0);
      ex_ready = 1;
      tick();
      chk("bp4_valid", ex_valid, 1);
      chk("bp4_op_b", ex_b, 7);
      chk("bp4_pc", ex_pc, 4);
      chk("bp4_ready", id_ready, 1);
      tick();
      chk("bp5_drained", ex_valid, 0);

      // Throughput with EX always ready
      for (int i = 0; i < 3; i++) begin
         drive(32'h10 + 32'(4 * i), (32'(i + 1) << 20) | 32'h93, c_addi);
         tick();
         chk("tput_valid", ex_valid, 1);
         chk("tput_op_b", ex_b, 32'(i + 1));
      end
      id_valid = 0;
      tick();

      // Forwarding sampled at accept, including the skid entry
      ex_ready = 0;
      fwd_data = {32'hDEAD_BEEF, 32'h0, 32'h0BAD_F00D};
      fwd_a_sel = 2'd3; fwd_b_sel = 2'd1;
      drive(32'h40, 32'h0000_0093, c_addi);
      tick();
      chk("fwd_op_a", ex_a, 32'hDEAD_BEEF);
      chk("fwd_lsu_wdata", ex_wd, 32'h0BAD_F00D);
      chk("fwd_op_b_imm", ex_b, 0);
      fwd_a_sel = 2'd2;
      fwd_data[63:32] = 32'hCAFE_F00D;
      drive(32'h44, 32'h0000_0093, c_addi);
      tick();
      id_valid = 0;
      fwd_data = {3{32'h1111_1111}};
      tick();
      chk("fwd_op_a_stable", ex_a, 32'hDEAD_BEEF);
      ex_ready = 1;
      tick();
      chk("fwd_skid_op_a", ex_a, 32'hCAFE_F00D);
      fwd_a_sel = 0; fwd_b_sel = 0; fwd_data = '0;
      tick();

      // BEQ x0,x0,+8 at 0x100: equal operands
      drive(32'h100, 32'h0000_0463, mk(c_imm_b, c_sel_a_pc, c_sel_b_imm, 1, 0, 0, 3'b000, 0));
      #1;
      chk("beq_take", take, 1);
      chk("beq_target", target, 32'h108);
      chk("beq_nb_take", nb_take, 0);
      tick();
      id_valid = 0;
      #1;
      chk("beq_take_once", take, 0);
      chk("beq_nb_cmp", nb_cmp, 3'b100);
      chk("beq_ex_pc", ex_pc, 32'h100);

      // BNE with equal operands: not taken
      drive(32'h100, 32'h0000_1463, mk(c_imm_b, c_sel_a_pc, c_sel_b_imm, 1, 0, 0, 3'b001, 0));
      #1;
      chk("bne_take", take, 0);
      tick();

      // BLT -1 < 1 signed taken, BLTU not taken
      fwd_data = {32'h0, 32'h0000_0001, 32'hFFFF_FFFF};
      fwd_a_sel = 2'd1; fwd_b_sel = 2'd2;
      drive(32'h100, 32'h0000_4463, mk(c_imm_b, c_sel_a_pc, c_sel_b_imm, 1, 0, 0, 3'b100, 0));
      #1;
      chk("blt_take", take, 1);
      tick();
      chk("blt_nb_cmp", nb_cmp, 3'b010);
      drive(32'h100, 32'h0000_6463, mk(c_imm_b, c_sel_a_pc, c_sel_b_imm, 1, 0, 0, 3'b110, 0));
      #1;
      chk("bltu_take", take, 0);
      tick();
      id_valid = 0; fwd_a_sel = 0; fwd_b_sel = 0;

      // JAL +16 at 0x200
      drive(32'h200, 32'h0100_006F, c_jal);
      #1;
      chk("jal_take", take, 1);
      chk("jal_target", target, 32'h210);
      tick();
      id_valid = 0;
      chk("jal_op_a_pc4", ex_a, 32'h204);
      chk("jal_no_exc", ex_exc, 0);

      // JALR 0(x1) with forwarded 0x202: misaligned target
      fwd_a_sel = 2'd1; fwd_data = {64'h0, 32'h0000_0202};
      drive(32'h300, 32'h0000_8067, mk(c_imm_i, c_sel_a_pc4, c_sel_b_zero, 0, 0, 1, 3'b000, 0));
      #1;
      chk("jalr_target", target, 32'h202);
      tick();
      id_valid = 0; fwd_a_sel = 0;
      chk("jalr_exc", ex_exc, 1);
      chk("jalr_xcause", ex_xc, E_INST_ADDR_MISALIGNED);
      chk("jalr_mtval", ex_mtval, 32'h202);

      // Illegal instruction, then fetch exception takes priority
      drive(32'h400, 32'hFFFF_FFFF, mk(3'd0, 2'd0, 2'd0, 0, 0, 0, 3'b000, 1));
      tick();
      chk("ill_xcause", ex_xc, E_ILLEGAL_INST);
      chk("ill_mtval", ex_mtval, 32'hFFFF_FFFF);
      if_exc = 1; if_xcause = 4'd1;
      tick();
      chk("ifx_xcause", ex_xc, 4'd1);
      chk("ifx_mtval", ex_mtval, 32'h400);
      if_exc = 0; if_xcause = 0; id_valid = 0;
      tick();

      // Register file: same-cycle read sees old value
      wb_wen = 1; wb_waddr = 5'd5; wb_wdata = 32'h11;
      tick();
      wb_wdata = 32'h22;
      drive(32'h500, 32'h0002_8313, c_addi);
      tick();
      chk("rf_old_value", ex_a, 32'h11);
      wb_wen = 0;
      tick();
      chk("rf_new_value", ex_a, 32'h22);
      id_valid = 0;
      tick();

      // Flush with skid FULL and a jump on the IF side
      ex_ready = 0;
      drive(32'h600, 32'h0050_0093, c_addi);
      tick();
      drive(32'h604, 32'h0070_0113, c_addi);
      tick();
      chk("fl_full", id_ready, 0);
      drive(32'h608, 32'h0100_006F, c_jal);
      flush = 1;
      #1;
      chk("fl_take_during", take, 0);
      tick();
      flush = 0; id_valid = 0;
      #1;
      chk("fl_ex_valid", ex_valid, 0);
      chk("fl_ready", id_ready, 1);
      chk("fl_take", take, 0);
      ex_ready = 1;
      tick();
      chk("fl_skid_dropped", ex_valid, 0);

      // Reset mid-stall drops the buffered instruction
      ex_ready = 0;
      drive(32'h700, 32'h0050_0093, c_addi);
      tick();
      drive(32'h704, 32'h0070_0113, c_addi);
      tick();
      id_valid = 0; rst = 1;
      tick();
      rst = 0;
      chk("rs_ex_valid", ex_valid, 0);
      chk("rs_ready", id_ready, 1);
      chk("rs_instr", ex_instr, 32'h0000_0013);
      ex_ready = 1;
      tick();
      chk("rs_no_ghost", ex_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
